// File: rtl/core_reg_bank_if.sv
// core_reg_bank_if: bus between the control unit (master) and the register bank (slave).
//   Load strobes : ld_rd, ld_sp, ld_lr, ld_pc, ld_apsr, ld_ipsr, ld_primask, pc_inc
//   Write data   : rd_addr, wr_data, sp_data, lr_data, pc_data, psr_data
//   Read ports   : rn_addr/rn_data, rm_addr/rm_data (combinational)
//   Views        : sp, lr, pc, apsr, ipsr, primask (zero-extended), wr_ack
interface core_reg_bank_if;
    logic        ld_rd;
    logic [3:0]  rd_addr;
    logic        ld_sp;
    logic        ld_lr;
    logic        ld_pc;
    logic        pc_inc;
    logic        ld_apsr;
    logic        ld_ipsr;
    logic        ld_primask;
    logic [31:0] wr_data;
    logic [31:0] sp_data;
    logic [31:0] lr_data;
    logic [31:0] pc_data;
    logic [31:0] psr_data;
    logic [3:0]  rn_addr;
    logic [3:0]  rm_addr;
    logic [31:0] rn_data;
    logic [31:0] rm_data;
    logic [31:0] sp;
    logic [31:0] lr;
    logic [31:0] pc;
    logic [31:0] apsr;
    logic [31:0] ipsr;
    logic [31:0] primask;
    logic        wr_ack;

    modport master (
        output ld_rd, rd_addr, ld_sp, ld_lr, ld_pc, pc_inc, ld_apsr, ld_ipsr, ld_primask,
        output wr_data, sp_data, lr_data, pc_data, psr_data, rn_addr, rm_addr,
        input  rn_data, rm_data, sp, lr, pc, apsr, ipsr, primask, wr_ack
    );

    modport slave (
        input  ld_rd, rd_addr, ld_sp, ld_lr, ld_pc, pc_inc, ld_apsr, ld_ipsr, ld_primask,
        input  wr_data, sp_data, lr_data, pc_data, psr_data, rn_addr, rm_addr,
        output rn_data, rm_data, sp, lr, pc, apsr, ipsr, primask, wr_ack
    );
endinterface

// File: rtl/core_reg_bank.sv
// core_reg_bank: Cortex-M0 architectural register bank (R0-R12, SP, LR, PC, APSR, IPSR,
// PRIMASK). Captures load strobes from the control unit, serves two combinational read
// ports, and pulses wr_ack the cycle after any ld_* strobe is accepted.
//   clk  : core clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : core_reg_bank_if.slave (strobes, write data, read ports, register views)
// Parameters: SP_RESET (bits [1:0] forced 0), PC_RESET (bit 0 forced 0).
// Optional: define CORE_REG_BYPASS_EN to forward same-cycle writes to the read ports.
module core_reg_bank #(
    parameter logic [31:0] SP_RESET = 32'h2000_1000,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst,
    core_reg_bank_if.slave bus
);

    localparam logic [31:0] SpRstVal = SP_RESET & 32'hFFFF_FFFC;
    localparam logic [31:0] PcRstVal = PC_RESET & 32'hFFFF_FFFE;

    logic [31:0] gpr_q [13];
    logic [31:0] gpr_d [13];
    logic [31:0] sp_q, sp_d;
    logic [31:0] lr_q, lr_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  apsr_q, apsr_d;
    logic [5:0]  ipsr_q, ipsr_d;
    logic        primask_q, primask_d;
    logic        wr_ack_q, wr_ack_d;

    logic        rd_hits_sp, rd_hits_lr, rd_hits_pc;
    logic        pc_wr;
    logic [31:0] pc_wr_val;
    logic [31:0] view [16];

    // Next-state with per-register write priority.
    always_comb begin
        rd_hits_sp = bus.ld_rd && (bus.rd_addr == 4'd13);
        rd_hits_lr = bus.ld_rd && (bus.rd_addr == 4'd14);
        rd_hits_pc = bus.ld_rd && (bus.rd_addr == 4'd15);

        gpr_d = gpr_q;
        for (int i = 0; i < 13; i++) begin
            if (bus.ld_rd && (bus.rd_addr == 4'(i))) begin
                gpr_d[i] = bus.wr_data;
            end
        end

        sp_d = sp_q;
        if (bus.ld_sp) begin
            sp_d = bus.sp_data & 32'hFFFF_FFFC;
        end else if (rd_hits_sp) begin
            sp_d = bus.wr_data & 32'hFFFF_FFFC;
        end

        lr_d = lr_q;
        if (bus.ld_lr) begin
            lr_d = bus.lr_data;
        end else if (rd_hits_lr) begin
            lr_d = bus.wr_data;
        end

        // Explicit loads win over the sequential increment.
        pc_wr     = bus.ld_pc || rd_hits_pc;
        pc_wr_val = bus.ld_pc ? (bus.pc_data & 32'hFFFF_FFFE) : (bus.wr_data & 32'hFFFF_FFFE);
        pc_d      = pc_q;
        if (pc_wr) begin
            pc_d = pc_wr_val;
        end else if (bus.pc_inc) begin
            pc_d = pc_q + 32'd2;
        end

        apsr_d    = bus.ld_apsr    ? bus.psr_data[31:28] : apsr_q;
        ipsr_d    = bus.ld_ipsr    ? bus.psr_data[5:0]   : ipsr_q;
        primask_d = bus.ld_primask ? bus.psr_data[0]     : primask_q;

        // pc_inc deliberately excluded: it is not an acknowledged load.
        wr_ack_d = bus.ld_rd | bus.ld_sp | bus.ld_lr | bus.ld_pc |
                   bus.ld_apsr | bus.ld_ipsr | bus.ld_primask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 13; i++) begin
                gpr_q[i] <= '0;
            end
            sp_q      <= SpRstVal;
            lr_q      <= '0;
            pc_q      <= PcRstVal;
            apsr_q    <= '0;
            ipsr_q    <= '0;
            primask_q <= 1'b0;
            wr_ack_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 13; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            sp_q      <= sp_d;
            lr_q      <= lr_d;
            pc_q      <= pc_d;
            apsr_q    <= apsr_d;
            ipsr_q    <= ipsr_d;
            primask_q <= primask_d;
            wr_ack_q  <= wr_ack_d;
        end
    end

    // Read view of all 16 indices; index 15 is the Thumb pipeline PC (+4).
    always_comb begin
`ifdef CORE_REG_BYPASS_EN
        // *_d already hold the post-priority, post-mask write value when written.
        for (int i = 0; i < 13; i++) begin
            view[i] = gpr_d[i];
        end
        view[13] = sp_d;
        view[14] = lr_d;
        // Increment is not forwarded, only explicit PC loads.
        view[15] = (pc_wr ? pc_wr_val : pc_q) + 32'd4;
`else
        for (int i = 0; i < 13; i++) begin
            view[i] = gpr_q[i];
        end
        view[13] = sp_q;
        view[14] = lr_q;
        view[15] = pc_q + 32'd4;
`endif
    end

    assign bus.rn_data = view[bus.rn_addr];
    assign bus.rm_data = view[bus.rm_addr];

    assign bus.sp      = sp_q;
    assign bus.lr      = lr_q;
    assign bus.pc      = pc_q;
    assign bus.apsr    = {apsr_q, 28'd0};
    assign bus.ipsr    = {26'd0, ipsr_q};
    assign bus.primask = {31'd0, primask_q};
    assign bus.wr_ack  = wr_ack_q;

endmodule
